// File: rtl/multi_timer_pkg.sv
// timer_pkg: register map, CTRL fields, MODE codes and FSM states
// shared by multi_timer, multi_timer_if and timer_channel.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PSC  = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_EXP  = 2'd2;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: CPU-side register bus (addr/we/WD/RD) plus IRQs.
// master = CPU bridge, slave = multi_timer.
interface multi_timer_if #(
  parameter int NCH = 2
);
  import timer_pkg::*;

  localparam int CH_W = ch_w(NCH);

  logic [CH_W+3:2] addr;
  logic            we;
  logic [31:0]     WD;
  logic [31:0]     RD;
  logic [NCH-1:0]  irq_vec;
  logic            IRQ;

  modport master (
    output addr, we, WD,
    input  RD, irq_vec, IRQ
  );

  modport slave (
    input  addr, we, WD,
    output RD, irq_vec, IRQ
  );

endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one down-counter with CTRL/PRESET/COUNT/STATUS.
// Ports: clk, rst_n, i_sel, i_we, i_reg, i_wd -> o_rd, o_irq.
// TIMER_PRESCALE_EN adds the CTRL[15:8] prescaler.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [1:0]  i_reg,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_irq
);

  logic             r_en;
  logic             r_im;
  logic             r_pend;
  logic [1:0]       r_mode;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       w_psc;
  logic             w_tick;
  logic             w_wr;

  assign w_wr = i_sel & i_we;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_psc;
  logic [7:0] r_pcnt;

  assign w_psc  = r_psc;
  assign w_tick = (r_pcnt == r_psc);

  // Outside an enabled CNT cycle the divider restarts, so every
  // load and every pause begins a fresh PSC+1 window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (!r_en || r_state != ST_CNT || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (w_wr && i_reg == REG_CTRL) begin
      r_psc <= i_wd[CTRL_PSC+:8];
    end
  end
`else
  assign w_psc  = '0;
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_im     <= 1'b0;
      r_pend   <= 1'b0;
      r_mode   <= MODE_ONESHOT;
      r_state  <= ST_IDLE;
      r_preset <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_en) begin
            r_count <= r_preset;
            r_state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (r_en && w_tick) begin
            if (r_count <= CNT_W'(1)) begin
              r_count <= '0;
              r_state <= ST_EXP;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        ST_EXP: begin
          r_pend <= 1'b1;
          if (r_mode == MODE_RELOAD) begin
            r_count <= r_preset;
            r_state <= ST_CNT;
          end else begin
            r_en    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // CPU writes come last so a CTRL write beats the EN clear.
      if (w_wr) begin
        unique case (i_reg)
          REG_CTRL: begin
            r_en   <= i_wd[CTRL_EN];
            r_mode <= i_wd[CTRL_MODE+:2];
            r_im   <= i_wd[CTRL_IM];
          end
          REG_PRESET: r_preset <= i_wd[CNT_W-1:0];
          REG_STATUS: begin
            if (i_wd[0] && r_state != ST_EXP) begin
              r_pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_rd = '0;
    unique case (i_reg)
      REG_CTRL: begin
        o_rd[CTRL_EN]       = r_en;
        o_rd[CTRL_MODE+:2]  = r_mode;
        o_rd[CTRL_IM]       = r_im;
        o_rd[CTRL_PSC+:8]   = w_psc;
      end
      REG_PRESET: o_rd = 32'(r_preset);
      REG_COUNT:  o_rd = 32'(r_count);
      REG_STATUS: o_rd[0] = r_pend;
    endcase
  end

  assign o_irq = r_im & r_pend;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NCH timer channels; channel decode, read mux, IRQ OR.
// Ports: clk, reset (async, active-low), bus (multi_timer_if.slave).
module multi_timer
  import timer_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          reset,
  multi_timer_if.slave bus
);

  localparam int CH_W = ch_w(NCH);

  logic [CH_W-1:0] w_idx;
  logic [1:0]      w_reg;
  logic [31:0]     w_rd [NCH];
  logic [NCH-1:0]  w_irq;
  logic [31:0]     w_rdata;

  assign w_idx = bus.addr[CH_W+3:4];
  assign w_reg = bus.addr[3:2];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst_n (reset),
      .i_sel (w_idx == CH_W'(g)),
      .i_we  (bus.we),
      .i_reg (w_reg),
      .i_wd  (bus.WD),
      .o_rd  (w_rd[g]),
      .o_irq (w_irq[g])
    );
  end

  // Indices with no channel match nothing and read as zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_idx == CH_W'(i)) begin
        w_rdata = w_rd[i];
      end
    end
  end

  assign bus.RD      = w_rdata;
  assign bus.irq_vec = w_irq;
  assign bus.IRQ     = |w_irq;

endmodule
